// File: rtl/strength_pkg.sv
// Shared strength codes, driver legality check and keeper state encoding for strength_resolver.
package strength_pkg;

    typedef logic [2:0] strength_t;

    localparam strength_t STR_HIGHZ  = 3'd0;
    localparam strength_t STR_SMALL  = 3'd1;
    localparam strength_t STR_MEDIUM = 3'd2;
    localparam strength_t STR_WEAK   = 3'd3;
    localparam strength_t STR_LARGE  = 3'd4;
    localparam strength_t STR_PULL   = 3'd5;
    localparam strength_t STR_STRONG = 3'd6;
    localparam strength_t STR_SUPPLY = 3'd7;

    // Charge-only codes (large, medium, small) are never legal on a driver.
    function automatic logic str_is_legal(input strength_t s);
        return !((s == STR_LARGE) || (s == STR_MEDIUM) || (s == STR_SMALL));
    endfunction

    typedef enum logic [2:0] {
        KP_DRIVEN,
        KP_LARGE,
        KP_MEDIUM,
        KP_SMALL,
        KP_FLOAT
    } keeper_state_t;

endpackage

// File: rtl/strength_keeper_bit.sv
// Per-bit charge keeper: holds the last driven value and decays large->medium->small->float.
module strength_keeper_bit
    import strength_pkg::*;
#(
    parameter int unsigned DECAY_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      driven,
    input  logic      res_val,
    input  logic      res_x,
    input  strength_t res_str,
    output logic      bus_val,
    output logic      bus_x,
    output logic      bus_z,
    output strength_t bus_str
);

    localparam int unsigned CW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_CYCLES - 1);

    keeper_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          val_d, x_d, z_d;
    strength_t     str_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KP_FLOAT;
            cnt_q   <= '0;
            bus_val <= 1'b0;
            bus_x   <= 1'b0;
            bus_z   <= 1'b1;
            bus_str <= STR_HIGHZ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_val <= val_d;
            bus_x   <= x_d;
            bus_z   <= z_d;
            bus_str <= str_d;
        end
    end

    // val/x stay frozen through the charge states because they default to the registered copy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = bus_val;
        x_d     = bus_x;
        z_d     = bus_z;
        str_d   = bus_str;
        if (driven) begin
            state_d = KP_DRIVEN;
            cnt_d   = '0;
            val_d   = res_val;
            x_d     = res_x;
            z_d     = 1'b0;
            str_d   = res_str;
        end else begin
            case (state_q)
                KP_DRIVEN: begin
                    state_d = KP_LARGE;
                    cnt_d   = '0;
                    str_d   = STR_LARGE;
                end
                KP_LARGE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = KP_MEDIUM;
                        cnt_d   = '0;
                        str_d   = STR_MEDIUM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                KP_MEDIUM: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = KP_SMALL;
                        cnt_d   = '0;
                        str_d   = STR_SMALL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                KP_SMALL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = KP_FLOAT;
                        cnt_d   = '0;
                        val_d   = 1'b0;
                        x_d     = 1'b0;
                        z_d     = 1'b1;
                        str_d   = STR_HIGHZ;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = KP_FLOAT;
                    cnt_d   = '0;
                    val_d   = 1'b0;
                    x_d     = 1'b0;
                    z_d     = 1'b1;
                    str_d   = STR_HIGHZ;
                end
            endcase
        end
    end

endmodule

// File: rtl/strength_resolver.sv
// Registered multi-driver bus strength resolver with contention tracking.
// Optional charge keeper on undriven bits when STRENGTH_KEEPER_EN is defined.
module strength_resolver
    import strength_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NDRV         = 4,
    parameter int unsigned DECAY_CYCLES = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NDRV*WIDTH-1:0]   drv_val,
    input  logic [NDRV*WIDTH*3-1:0] drv_str,
    input  logic                    cnt_clr,
    output logic [WIDTH-1:0]        bus_val,
    output logic [WIDTH*3-1:0]      bus_str,
    output logic [WIDTH-1:0]        bus_x,
    output logic [WIDTH-1:0]        bus_z,
    output logic [WIDTH-1:0]        contention,
    output logic [CNT_W-1:0]        cont_cnt,
    output logic                    illegal_err
);

    if (NDRV < 2 || DECAY_CYCLES < 1) begin : g_param_check
        $error("strength_resolver: NDRV must be >= 2 and DECAY_CYCLES >= 1");
    end

    logic [WIDTH-1:0]   res_val, res_x, res_drv;
    logic [WIDTH*3-1:0] res_str;
    logic               illegal_any;

    // Per bit: strongest legal driver wins; disagreement at that strength is contention.
    always_comb begin : resolve
        strength_t s_max, s_eff;
        logic      any1, any0;
        s_max       = STR_HIGHZ;
        s_eff       = STR_HIGHZ;
        any1        = 1'b0;
        any0        = 1'b0;
        res_val     = '0;
        res_x       = '0;
        res_drv     = '0;
        res_str     = '0;
        illegal_any = 1'b0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            s_max = STR_HIGHZ;
            any1  = 1'b0;
            any0  = 1'b0;
            for (int unsigned d = 0; d < NDRV; d++) begin
                s_eff = drv_str[(d*WIDTH+b)*3 +: 3];
                if (!str_is_legal(s_eff)) begin
                    illegal_any = 1'b1;
                    s_eff       = STR_HIGHZ;
                end
                if (s_eff > s_max) begin
                    s_max = s_eff;
                    any1  = drv_val[d*WIDTH+b];
                    any0  = !drv_val[d*WIDTH+b];
                end else if (s_eff == s_max) begin
                    any1 = any1 | drv_val[d*WIDTH+b];
                    any0 = any0 | !drv_val[d*WIDTH+b];
                end
            end
            res_drv[b]       = (s_max != STR_HIGHZ);
            res_str[b*3 +: 3] = s_max;
            res_x[b]         = res_drv[b] && any1 && any0;
            res_val[b]       = res_drv[b] && any1 && !any0;
        end
    end

`ifdef STRENGTH_KEEPER_EN
    for (genvar b = 0; b < WIDTH; b++) begin : g_keeper
        strength_keeper_bit #(
            .DECAY_CYCLES(DECAY_CYCLES)
        ) u_keeper (
            .clk    (clk),
            .rst_n  (rst_n),
            .driven (res_drv[b]),
            .res_val(res_val[b]),
            .res_x  (res_x[b]),
            .res_str(res_str[b*3 +: 3]),
            .bus_val(bus_val[b]),
            .bus_x  (bus_x[b]),
            .bus_z  (bus_z[b]),
            .bus_str(bus_str[b*3 +: 3])
        );
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_val <= '0;
            bus_x   <= '0;
            bus_z   <= '1;
            bus_str <= '0;
        end else begin
            bus_val <= res_val;
            bus_x   <= res_x;
            bus_z   <= ~res_drv;
            bus_str <= res_str;
        end
    end
`endif

    // Clear wins over both the increment and the sticky error set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention  <= '0;
            cont_cnt    <= '0;
            illegal_err <= 1'b0;
        end else begin
            contention <= res_x;
            if (cnt_clr) begin
                cont_cnt    <= '0;
                illegal_err <= 1'b0;
            end else begin
                if ((|res_x) && (cont_cnt != {CNT_W{1'b1}})) begin
                    cont_cnt <= cont_cnt + CNT_W'(1);
                end
                if (illegal_any) begin
                    illegal_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_strength_resolver.sv
// Self-checking bench for strength_resolver: age-based behavioural model plus directed literals.
`timescale 1ns/1ps
module tb_strength_resolver;
    import strength_pkg::*;

    localparam int WIDTH = 2;
    localparam int NDRV  = 2;
    localparam int DECAY = 2;
    localparam int CNT_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NDRV*WIDTH-1:0]   drv_val = '0;
    logic [NDRV*WIDTH*3-1:0] drv_str = '0;
    logic                    cnt_clr = 1'b0;
    logic [WIDTH-1:0]        bus_val, bus_x, bus_z, contention;
    logic [WIDTH*3-1:0]      bus_str;
    logic [CNT_W-1:0]        cont_cnt;
    logic                    illegal_err;

    int n_checks = 0;
    int n_fail   = 0;

    strength_resolver #(
        .WIDTH(WIDTH), .NDRV(NDRV), .DECAY_CYCLES(DECAY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drv_val(drv_val), .drv_str(drv_str), .cnt_clr(cnt_clr),
        .bus_val(bus_val), .bus_str(bus_str), .bus_x(bus_x), .bus_z(bus_z),
        .contention(contention), .cont_cnt(cont_cnt), .illegal_err(illegal_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: expected outputs plus, per bit, age since last driven sample.
    logic [WIDTH-1:0]   e_val, e_x, e_z, e_cont, n_val, n_x, n_z, n_cont;
    logic [WIDTH*3-1:0] e_str, n_str;
    logic [CNT_W-1:0]   e_cnt, n_cnt;
    logic               e_ill, n_ill;
    int                 e_age [WIDTH];
    int                 n_age [WIDTH];
    bit                 e_have [WIDTH];
    bit                 n_have [WIDTH];
    logic               e_hval [WIDTH];
    logic               n_hval [WIDTH];
    logic               e_hx [WIDTH];
    logic               n_hx [WIDTH];

    always_comb begin : model_next
        int smax, ones, zeros, s, age;
        smax = 0; ones = 0; zeros = 0; s = 0; age = 0;
        n_val = '0; n_x = '0; n_z = '0; n_str = '0; n_cont = '0;
        n_ill = e_ill; n_cnt = e_cnt;
        for (int b = 0; b < WIDTH; b++) begin
            n_age[b] = e_age[b]; n_have[b] = e_have[b];
            n_hval[b] = e_hval[b]; n_hx[b] = e_hx[b];
            smax = 0; ones = 0; zeros = 0;
            for (int d = 0; d < NDRV; d++) begin
                s = int'(drv_str[(d*WIDTH+b)*3 +: 3]);
                if (s == 4 || s == 2 || s == 1) begin
                    n_ill = 1'b1;
                    s = 0;
                end
                if (s > smax) smax = s;
            end
            for (int d = 0; d < NDRV; d++) begin
                s = int'(drv_str[(d*WIDTH+b)*3 +: 3]);
                if (smax > 0 && s == smax) begin
                    if (drv_val[d*WIDTH+b]) ones++;
                    else zeros++;
                end
            end
            if (smax > 0) begin
                n_str[b*3 +: 3] = 3'(smax);
                n_x[b]    = (ones > 0) && (zeros > 0);
                n_val[b]  = (ones > 0) && (zeros == 0);
                n_cont[b] = n_x[b];
                n_have[b] = 1'b1;
                n_age[b]  = 0;
                n_hval[b] = n_val[b];
                n_hx[b]   = n_x[b];
            end else begin
                n_z[b] = 1'b1;
`ifdef STRENGTH_KEEPER_EN
                if (e_have[b]) begin
                    age = e_age[b] + 1;
                    if (age > 3*DECAY) age = 3*DECAY + 1;
                    n_age[b] = age;
                    if (age <= 3*DECAY) begin
                        n_z[b]   = 1'b0;
                        n_val[b] = e_hval[b];
                        n_x[b]   = e_hx[b];
                        n_str[b*3 +: 3] = (age <= DECAY) ? 3'd4 : ((age <= 2*DECAY) ? 3'd2 : 3'd1);
                    end
                end
`endif
            end
        end
        if (n_cont != '0) n_cnt = (e_cnt == {CNT_W{1'b1}}) ? e_cnt : e_cnt + 4'd1;
        if (cnt_clr) begin
            n_cnt = '0;
            n_ill = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_val <= '0; e_x <= '0; e_z <= '1; e_str <= '0; e_cont <= '0;
            e_cnt <= '0; e_ill <= 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                e_age[b] <= 0; e_have[b] <= 1'b0; e_hval[b] <= 1'b0; e_hx[b] <= 1'b0;
            end
        end else begin
            e_val <= n_val; e_x <= n_x; e_z <= n_z; e_str <= n_str; e_cont <= n_cont;
            e_cnt <= n_cnt; e_ill <= n_ill;
            for (int b = 0; b < WIDTH; b++) begin
                e_age[b] <= n_age[b]; e_have[b] <= n_have[b];
                e_hval[b] <= n_hval[b]; e_hx[b] <= n_hx[b];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model bus_val", 32'(bus_val), 32'(e_val));
        check("model bus_str", 32'(bus_str), 32'(e_str));
        check("model bus_x", 32'(bus_x), 32'(e_x));
        check("model bus_z", 32'(bus_z), 32'(e_z));
        check("model contention", 32'(contention), 32'(e_cont));
        check("model cont_cnt", 32'(cont_cnt), 32'(e_cnt));
        check("model illegal_err", 32'(illegal_err), 32'(e_ill));
    end

    // Same driver pair applied to both bits.
    task automatic drv2(input logic v0, input logic [2:0] s0, input logic v1, input logic [2:0] s1);
        drv_val = {v1, v1, v0, v0};
        drv_str = {s1, s1, s0, s0};
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] str2(input logic [2:0] s);
        return {s, s};
    endfunction

    initial begin
        logic [2:0] exp_str [6];
        exp_str = '{3'd4, 3'd4, 3'd2, 3'd2, 3'd1, 3'd1};

        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ);
        #7;
        check("reset bus_z", 32'(bus_z), 32'h3);
        check("reset bus_str", 32'(bus_str), 32'h0);
        check("reset cont_cnt", 32'(cont_cnt), 32'h0);
        #15 rst_n = 1'b1;
        cyc(1);

        drv2(1'b0, STR_SUPPLY, 1'b1, STR_WEAK); cyc(1);
        check("supply0 vs weak1 val", 32'(bus_val), 32'h0);
        check("supply0 vs weak1 str", 32'(bus_str), 32'(str2(3'd7)));
        drv2(1'b1, STR_PULL, 1'b0, STR_WEAK); cyc(1);
        check("pull1 vs weak0 val", 32'(bus_val), 32'h3);
        check("pull1 vs weak0 str", 32'(bus_str), 32'(str2(3'd5)));
        drv2(1'b1, STR_PULL, 1'b1, STR_STRONG); cyc(1);
        check("pull1 vs strong1 val", 32'(bus_val), 32'h3);
        check("pull1 vs strong1 str", 32'(bus_str), 32'(str2(3'd6)));

        drv2(1'b0, STR_STRONG, 1'b1, STR_STRONG); cyc(3);
        check("conflict bus_x", 32'(bus_x), 32'h3);
        check("conflict contention", 32'(contention), 32'h3);
        check("conflict cont_cnt", 32'(cont_cnt), 32'd3);
        cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        check("clr over incr", 32'(cont_cnt), 32'd0);

        // Decay sequence after a strong 1.
        drv2(1'b1, STR_STRONG, 1'b0, STR_HIGHZ); cyc(1);
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
`ifdef STRENGTH_KEEPER_EN
            check("decay str", 32'(bus_str), 32'(str2(exp_str[i])));
            check("decay val", 32'(bus_val), 32'h3);
`else
            check("undriven z", 32'(bus_z), 32'h3);
`endif
        end
        cyc(1);
        check("decayed float", 32'(bus_z), 32'h3);

        // Re-drive with a weak driver while in medium charge.
        drv2(1'b1, STR_STRONG, 1'b0, STR_HIGHZ); cyc(1);
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ); cyc(3);
        drv2(1'b0, STR_WEAK, 1'b0, STR_HIGHZ); cyc(1);
        check("redrive val", 32'(bus_val), 32'h0);
        check("redrive str", 32'(bus_str), 32'(str2(3'd3)));
        check("redrive z", 32'(bus_z), 32'h0);

        // Async reset while in large charge.
        drv2(1'b1, STR_STRONG, 1'b0, STR_HIGHZ); cyc(1);
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ); cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst bus_z", 32'(bus_z), 32'h3);
        check("async rst bus_str", 32'(bus_str), 32'h0);
        check("async rst bus_val", 32'(bus_val), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(2);
        check("post-reset nothing held", 32'(bus_z), 32'h3);

        // Charge-only code from a driver.
        drv2(1'b1, STR_LARGE, 1'b0, STR_HIGHZ); cyc(1);
        check("illegal as highz", 32'(bus_z), 32'h3);
        check("illegal_err set", 32'(illegal_err), 32'h1);
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ); cyc(2);
        check("illegal_err sticky", 32'(illegal_err), 32'h1);
        drv2(1'b1, STR_SMALL, 1'b0, STR_HIGHZ);
        cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        check("clr over illegal", 32'(illegal_err), 32'h0);
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ); cyc(1);

        // Per-bit independence.
        drv_val = 4'b1001;
        drv_str = {3'd5, 3'd0, 3'd5, 3'd6};
        cyc(1);
        check("mixed val", 32'(bus_val), 32'h1);
        check("mixed x", 32'(bus_x), 32'h2);
        check("mixed str", 32'(bus_str), 32'(6'b101110));
        check("mixed contention", 32'(contention), 32'h2);

        cnt_clr = 1'b1; drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ); cyc(1); cnt_clr = 1'b0;
        drv2(1'b1, STR_SUPPLY, 1'b0, STR_SUPPLY); cyc(20);
        check("cont_cnt saturates", 32'(cont_cnt), 32'd15);

        // Random traffic checked against the model only.
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < NDRV*WIDTH; k++) begin
                drv_val[k] = 1'($urandom_range(0, 1));
                drv_str[k*3 +: 3] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            end
            cnt_clr = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        cnt_clr = 1'b0;
        drv2(1'b0, STR_HIGHZ, 1'b0, STR_HIGHZ);
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
